// File: rtl/fifo_mem_pkg.sv
// fifo_mem_pkg: default sizing and the data word type shared by the FIFO slice.
package fifo_mem_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefDepth     = 16;

   typedef logic [DefDataWidth-1:0] word_t;

endpackage

// File: rtl/fifo_mem_if.sv
// fifo_if: producer/consumer handshake bundle for fifo_mem.
// Optional overflow/underflow pulses exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_if
   import fifo_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth
);

   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;
`endif

   // Producer/consumer side
   modport master (
      output data_in, wr, rd,
`ifdef FIFO_ERR_FLAGS_EN
      input  overflow, underflow,
`endif
      input  data_out, full, empty
   );

   // FIFO side
   modport slave (
      input  data_in, wr, rd,
`ifdef FIFO_ERR_FLAGS_EN
      output overflow, underflow,
`endif
      output data_out, full, empty
   );

endinterface

// File: rtl/fifo_mem_ram.sv
// fifo_mem_ram: simple dual-port register array, one write port and a registered read port.
// Storage is never reset; only the read register clears so the output is X-free after reset.
module fifo_mem_ram
   import fifo_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; holds its value when no read is requested
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_mem.sv
// fifo_mem: single-clock synchronous FIFO with full/empty flags and registered read data.
// Define FIFO_ERR_FLAGS_EN to add one-cycle overflow/underflow pulses on the interface.
module fifo_mem
   import fifo_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned DEPTH      = DefDepth,
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input logic   clk,
   input logic   rst,
   fifo_if.slave bus
);

   localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full, empty;
   logic                  wr_acc, rd_acc;

   assign full  = (count_q == FullCount);
   assign empty = (count_q == '0);

   // Accept logic and next-state pointers/count; flags gate each side independently,
   // so a simultaneous request at full only reads and at empty only writes
   always_comb begin
      wr_acc   = bus.wr && !full;
      rd_acc   = bus.rd && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_mem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.data_in),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (bus.data_out)
   );

   assign bus.full  = full;
   assign bus.empty = empty;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   // Error pulses: a write lost at full (no freeing read) or a read at empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= bus.wr && full && !bus.rd;
         underflow_q <= bus.rd && empty;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: directed self-checking bench for fifo_mem (default 8 x 16).
// Define FIFO_ERR_FLAGS_EN to also check the overflow/underflow pulses.
module tb_fifo_mem;
   import fifo_mem_pkg::*;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   fifo_if #(.DATA_WIDTH(8)) bus ();

   fifo_mem #(
      .DATA_WIDTH (8),
      .DEPTH      (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes; returns #1 after the edge
   task automatic cyc(input logic w, input logic r, input word_t d);
      bus.wr      = w;
      bus.rd      = r;
      bus.data_in = d;
      @(posedge clk);
      #1;
      bus.wr      = 1'b0;
      bus.rd      = 1'b0;
   endtask

   initial begin
      word_t v;
      rst         = 1'b0;
      bus.wr      = 1'b0;
      bus.rd      = 1'b0;
      bus.data_in = '0;

      // Reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_dout", 32'(bus.data_out), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_udf", 32'(bus.underflow), 32'd0);
`endif
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);

      // Ordering
      cyc(1'b1, 1'b0, 8'h11);
      check("ord_nempty", 32'(bus.empty), 32'd0);
      cyc(1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 8'h33);
      cyc(1'b0, 1'b1, 8'h00);
      check("ord_rd0", 32'(bus.data_out), 32'h11);
      cyc(1'b0, 1'b1, 8'h00);
      check("ord_rd1", 32'(bus.data_out), 32'h22);
      check("ord_nempty2", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      check("ord_rd2", 32'(bus.data_out), 32'h33);
      check("ord_empty", 32'(bus.empty), 32'd1);

      // Read while empty: data_out holds, pointers stay put
      cyc(1'b0, 1'b1, 8'h00);
      check("erd_hold", 32'(bus.data_out), 32'h33);
      check("erd_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      check("erd_udf", 32'(bus.underflow), 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      check("erd_udf_clr", 32'(bus.underflow), 32'd0);
`endif
      cyc(1'b1, 1'b0, 8'h44);
      cyc(1'b0, 1'b1, 8'h00);
      check("erd_ptr", 32'(bus.data_out), 32'h44);
      check("erd_empty2", 32'(bus.empty), 32'd1);

      // Fill to 16, 17th write dropped
      for (int i = 0; i < 16; i++) begin
         v = word_t'(i);
         cyc(1'b1, 1'b0, v);
         if (i == 14) check("fill_nfull15", 32'(bus.full), 32'd0);
      end
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_nempty", 32'(bus.empty), 32'd0);
      cyc(1'b1, 1'b0, 8'hAA);
      check("fill_full17", 32'(bus.full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      check("fill_ovf", 32'(bus.overflow), 32'd1);
`endif
      cyc(1'b0, 1'b0, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
      check("fill_ovf_clr", 32'(bus.overflow), 32'd0);
`endif
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check($sformatf("fill_rd%0d", i), 32'(bus.data_out), 32'(i));
         if (i == 0) check("fill_nfull", 32'(bus.full), 32'd0);
         if (i == 14) check("fill_nempty15", 32'(bus.empty), 32'd0);
      end
      check("fill_empty", 32'(bus.empty), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);
      check("fill_noaa", 32'(bus.data_out), 32'h0F);

      // Simultaneous at count 4
      cyc(1'b1, 1'b0, 8'h21);
      cyc(1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 8'h23);
      cyc(1'b1, 1'b0, 8'h24);
      cyc(1'b1, 1'b1, 8'h5A);
      check("sim4_rd", 32'(bus.data_out), 32'h21);
      cyc(1'b0, 1'b1, 8'h00);
      check("sim4_rd1", 32'(bus.data_out), 32'h22);
      cyc(1'b0, 1'b1, 8'h00);
      check("sim4_rd2", 32'(bus.data_out), 32'h23);
      cyc(1'b0, 1'b1, 8'h00);
      check("sim4_rd3", 32'(bus.data_out), 32'h24);
      check("sim4_nempty", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      check("sim4_rd4", 32'(bus.data_out), 32'h5A);
      check("sim4_empty", 32'(bus.empty), 32'd1);

      // Simultaneous at full: read wins, write dropped
      for (int i = 0; i < 16; i++) begin
         v = word_t'(8'h80 + i);
         cyc(1'b1, 1'b0, v);
      end
      check("simf_full", 32'(bus.full), 32'd1);
      cyc(1'b1, 1'b1, 8'hEE);
      check("simf_rd", 32'(bus.data_out), 32'h80);
      check("simf_nfull", 32'(bus.full), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      check("simf_noovf", 32'(bus.overflow), 32'd0);
`endif
      for (int i = 1; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         if (i == 14) check("simf_nempty", 32'(bus.empty), 32'd0);
      end
      check("simf_last", 32'(bus.data_out), 32'h8F);
      check("simf_empty", 32'(bus.empty), 32'd1);
      cyc(1'b0, 1'b1, 8'h00);
      check("simf_noee", 32'(bus.data_out), 32'h8F);

      // Simultaneous at empty: write only, no fall-through
      cyc(1'b1, 1'b1, 8'h77);
      check("sime_hold", 32'(bus.data_out), 32'h8F);
      check("sime_nempty", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      check("sime_rd", 32'(bus.data_out), 32'h77);
      check("sime_empty", 32'(bus.empty), 32'd1);

      // Wrap-around with interleaved write/read pairs
      for (int i = 0; i < 40; i++) begin
         v = word_t'(8'h30 + i);
         cyc(1'b1, 1'b0, v);
         cyc(1'b0, 1'b1, 8'h00);
         check($sformatf("wrap%0d", i), 32'(bus.data_out), 32'(v));
      end
      check("wrap_empty", 32'(bus.empty), 32'd1);

      // Asynchronous reset mid-stream with 5 entries queued
      for (int i = 0; i < 5; i++) begin
         v = word_t'(8'hD0 + i);
         cyc(1'b1, 1'b0, v);
      end
      check("mrst_nempty", 32'(bus.empty), 32'd0);
      rst = 1'b0;
      #2;
      check("mrst_empty", 32'(bus.empty), 32'd1);
      check("mrst_full", 32'(bus.full), 32'd0);
      check("mrst_dout", 32'(bus.data_out), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1, 1'b0, 8'h99);
      cyc(1'b0, 1'b1, 8'h00);
      check("mrst_after", 32'(bus.data_out), 32'h99);
      check("mrst_empty2", 32'(bus.empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_mem.md
Name: fifo_mem

Overview:
- Single-clock synchronous FIFO buffer with write/read strobes and full/empty status flags.
- Sits between a producer and a consumer in one clock domain.
- Verification drives it through the existing fifo_if interface (data_in, wr, rd, data_out, full, empty), with the bench supplying clk and rst.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- data_in  input  DATA_WIDTH  write data, sampled when a write is accepted.
- wr  input  1  write request.
- rd  input  1  read request.
- data_out  output  DATA_WIDTH  read data, registered.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0. Storage contents are not cleared. Release is synchronous to clk.
- Write accepted when wr && !full at a rising edge: mem[wr_ptr] <= data_in; wr_ptr increments.
- Read accepted when rd && !empty at a rising edge: data_out <= mem[rd_ptr]; rd_ptr increments.
- Read latency: data_out is valid the cycle after the accepted read edge. It holds its last value when no read is accepted.
- Pointers wrap modulo DEPTH (natural ADDR_WIDTH rollover).
- count: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither.
- full and empty are derived combinationally from count; they must never both be high.
- Simultaneous wr && rd:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write ignored, so count becomes DEPTH-1.
  - Empty: write accepted, read ignored. There is no fall-through; data_out is unchanged.
- Write when full: ignored; no state change, data dropped.
- Read when empty: ignored; data_out holds.
- Reset mid-operation: all pointers and flags return to reset values immediately. Queued data is discarded logically.
- No X propagation on outputs after reset.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow and underflow (1 bit each).
  - overflow is a one-cycle pulse, registered on the edge where wr && full && !rd.
  - underflow is a one-cycle pulse where rd && empty.
  - Both reset to 0.
- Undefined: these ports and their logic do not exist; the rest of the behaviour is identical.

Decomposition:
- Package fifo_mem_pkg holds the default DATA_WIDTH/DEPTH localparams and a typedef for the data word (logic [DATA_WIDTH-1:0]).
- One sub-module, fifo_mem_ram: a simple dual-port register array with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
- fifo_mem keeps the pointers, count, flags and accept logic.

Test Plan:
- Reset check: hold rst low for 2 cycles -> empty=1, full=0, data_out=0. Asserting rst low mid-stream with count=5 -> empty=1 immediately, without waiting for a clock.
- Ordering: write 0x11, 0x22, 0x33, then 3 reads -> data_out 0x11, 0x22, 0x33 on successive cycles after each read edge; empty=1 after the third.
- Fill: 16 writes of 0x00..0x0F -> full=1 after the 16th. A 17th write of 0xAA is dropped. 16 reads return 0x00..0x0F, with no 0xAA.
- Empty read: rd=1 with empty=1 -> data_out holds its previous value and pointers are unchanged (no wrap corruption on subsequent writes).
- Simultaneous: at count=4, wr=1/rd=1 with data_in=0x5A -> count stays 4 and oldest data is read. At full, wr=rd=1 -> count becomes 15 and the write is dropped.
- Wrap-around: 40 interleaved write/read pairs with incrementing data -> the read stream equals the write stream across pointer wrap. With FIFO_ERR_FLAGS_EN, a write at full pulses overflow for one cycle.
